// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared types and constants for the PS/2 device-to-host receiver.
//   ps2_state_e : receive FSM state encoding (values fixed by ST_* constants
//                 so existing logic that decodes the raw 2-bit code still works)
//   ps2_entry_t : one FIFO entry {stop_err, parity_err, data[7:0]}
//   odd_parity  : the parity bit a correct sender puts after a byte
// ---------------------------------------------------------------------------
package ps2_pkg;

   localparam int PS2_DATA_BITS = 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP
   } ps2_state_e;

   typedef struct packed {
      logic                     stop_err;
      logic                     parity_err;
      logic [PS2_DATA_BITS-1:0] data;
   } ps2_entry_t;

   // PS/2 uses odd parity: data bits plus parity bit hold an odd number of 1s.
   function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_sync_filt.sv
// ---------------------------------------------------------------------------
// ps2_sync_filt
// Brings one asynchronous PS/2 pin into the clk_sys domain and removes short
// glitches. The output only follows the synchronized input after the input
// has disagreed with it for FILT_LEN consecutive cycles.
// Ports:
//   clk_sys : system clock
//   rst_n   : asynchronous active-low reset (output resets to 1, the idle
//             level of an open-collector PS/2 line)
//   pin     : raw asynchronous pin
//   filt    : synchronized, glitch-filtered level
// ---------------------------------------------------------------------------
module ps2_sync_filt #(
   parameter int FILT_LEN = 4
) (
   input  logic clk_sys,
   input  logic rst_n,
   input  logic pin,
   output logic filt
);

   logic [1:0] sync_q;
   logic [3:0] stable_cnt;

   // NOTE: every clocked register uses non-blocking assignment so all flops
   // sample their inputs from the same pre-edge values.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= 2'b11;
         stable_cnt <= '0;
         filt       <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], pin};
         if (sync_q[1] == filt) begin
            stable_cnt <= '0;
         end else if (stable_cnt == 4'(FILT_LEN - 1)) begin
            // This cycle is the FILT_LEN-th in a row of disagreement.
            filt       <= sync_q[1];
            stable_cnt <= '0;
         end else begin
            stable_cnt <= stable_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo
// PS/2 device-to-host receiver with pin filtering, a per-frame watchdog,
// per-byte error flags and a show-ahead output FIFO.
// Ports:
//   clk_sys, rst_n        : system clock, asynchronous active-low reset
//   PS2_CLK, PS2_DATA     : raw asynchronous PS/2 pins
//   en                    : receive enable; low aborts the current frame
//   m_valid/m_ready       : FIFO head handshake (pop on m_valid & m_ready)
//   m_data, m_parity_err,
//   m_stop_err            : head entry (forced to 0 while m_valid is low)
//   fifo_level            : number of entries held
//   timeout_pulse         : one-cycle pulse when the watchdog aborts a frame
//   overflow, ovf_clr     : sticky "frame lost to full FIFO" flag and its clear
// ---------------------------------------------------------------------------
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int FILT_LEN    = 4,
   parameter int TIMEOUT_CYC = 100000,
   parameter int FIFO_DEPTH  = 8,
   parameter int DROP_BAD    = 0
) (
   input  logic                          clk_sys,
   input  logic                          rst_n,
   input  logic                          PS2_CLK,
   input  logic                          PS2_DATA,
   input  logic                          en,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [7:0]                    m_data,
   output logic                          m_parity_err,
   output logic                          m_stop_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          timeout_pulse,
   output logic                          overflow,
   input  logic                          ovf_clr
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int WD_W  = $clog2(TIMEOUT_CYC) + 1;

   // The watchdog fires on the edge where the count would reach TIMEOUT_CYC-1,
   // so the pulse lands exactly TIMEOUT_CYC cycles after the last fall.
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 2);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
   localparam logic [2:0]       BIT_LAST = 3'(PS2_DATA_BITS - 1);

   // ---------------------------------------------------------------- pins
   logic clk_f;
   logic data_f;
   logic clk_f_q;
   logic fall;

   ps2_sync_filt #(.FILT_LEN(FILT_LEN)) u_clk_filt (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .pin     (PS2_CLK),
      .filt    (clk_f)
   );

   ps2_sync_filt #(.FILT_LEN(FILT_LEN)) u_data_filt (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .pin     (PS2_DATA),
      .filt    (data_f)
   );

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         clk_f_q <= 1'b1;
         fall    <= 1'b0;
      end else begin
         clk_f_q <= clk_f;
         fall    <= clk_f_q & ~clk_f;
      end
   end

   // ----------------------------------------------------------------- FSM
   ps2_state_e               state;
   logic [2:0]               bit_cnt;
   logic [PS2_DATA_BITS-1:0] shreg;
   logic                     par_q;
   logic [WD_W-1:0]          wd_cnt;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         bit_cnt       <= '0;
         shreg         <= '0;
         par_q         <= 1'b0;
         wd_cnt        <= '0;
         timeout_pulse <= 1'b0;
      end else if (!en) begin
         state         <= IDLE;
         bit_cnt       <= '0;
         wd_cnt        <= '0;
         timeout_pulse <= 1'b0;
      end else begin
         timeout_pulse <= 1'b0;

         if (state == IDLE || fall) begin
            wd_cnt <= '0;
         end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
         end

         if (fall) begin
            case (state)
               IDLE: begin
                  // A high data level on a fall is line noise, not a start bit.
                  if (!data_f) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  shreg   <= {data_f, shreg[PS2_DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == BIT_LAST) begin
                     state <= PARITY;
                  end
               end
               PARITY: begin
                  par_q <= data_f;
                  state <= STOP;
               end
               STOP: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end else if (state != IDLE && wd_cnt == WD_LAST) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            wd_cnt        <= '0;
            timeout_pulse <= 1'b1;
         end
      end
   end

   // --------------------------------------------------------- frame entry
   logic       frame_done;
   ps2_entry_t entry;

   assign frame_done       = en && fall && (state == STOP);
   assign entry.data       = shreg;
   assign entry.parity_err = (par_q != odd_parity(shreg));
   assign entry.stop_err   = ~data_f;

   // ---------------------------------------------------------------- FIFO
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] level;
   ps2_entry_t       mem [FIFO_DEPTH];
   ps2_entry_t       head;
   logic             full;
   logic             pop;
   logic             push;
   logic             drop_full;

   assign m_valid = (level != '0);

   // NOTE: push/drop_full get defaults before any condition so this block
   // stays purely combinational and never infers a latch.
   always_comb begin
      full      = (level == LVL_FULL);
      pop       = m_valid && m_ready;
      push      = 1'b0;
      drop_full = 1'b0;
      if (frame_done && !((DROP_BAD != 0) && (entry.parity_err || entry.stop_err))) begin
         // A same-cycle pop frees the slot, so a full FIFO can still accept.
         if (!full || pop) begin
            push = 1'b1;
         end else begin
            drop_full = 1'b1;
         end
      end
   end

   // NOTE: the storage array has no reset; validity is carried entirely by
   // the level counter, and the outputs are gated so stale data never shows.
   always_ff @(posedge clk_sys) begin
      if (push) begin
         mem[wr_ptr] <= entry;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (drop_full) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

   assign head         = mem[rd_ptr];
   assign m_data       = m_valid ? head.data       : '0;
   assign m_parity_err = m_valid ? head.parity_err : 1'b0;
   assign m_stop_err   = m_valid ? head.stop_err   : 1'b0;
   assign fifo_level   = level;

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver: next generation of the single-byte PS/2 receiver. It adds a digital glitch filter on PS2_CLK, a per-frame watchdog timeout, per-byte (non-sticky) error flags and an output FIFO with a valid/ready handshake. It sits between the PS/2 pins and the keyboard/mouse decode logic on the 50 MHz system clock. Host-to-device transmission is out of scope.

## Interface
- `FILT_LEN`, 4: consecutive stable `clk_sys` cycles required before the filtered PS2_CLK/PS2_DATA level changes; range 1..15.
- `TIMEOUT_CYC`, 100000: `clk_sys` cycles allowed between falling edges inside a frame (2 ms at 50 MHz); must be ≥ 2.
- `FIFO_DEPTH`, 8: output FIFO entries; power of 2, ≥ 2.
- `DROP_BAD`, 0: 1 = frames with a parity or stop error are discarded instead of written.
- `clk_sys` in 1: system clock, one clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `PS2_CLK` in 1: raw PS/2 clock pin, asynchronous.
- `PS2_DATA` in 1: raw PS/2 data pin, asynchronous.
- `en` in 1: receive enable; low aborts any frame and holds the FSM in IDLE. FIFO contents are kept.
- `m_valid` out 1: FIFO head is valid.
- `m_ready` in 1: consumer accepts the head entry.
- `m_data` out 8: received byte.
- `m_parity_err` out 1: odd-parity mismatch for this byte.
- `m_stop_err` out 1: stop bit sampled as 0 for this byte.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: entries held.
- `timeout_pulse` out 1: one-cycle pulse when a frame is aborted by the watchdog.
- `overflow` out 1: sticky; set when a frame is dropped because the FIFO is full.
- `ovf_clr` in 1: synchronous clear of `overflow`. Set wins if both occur in the same cycle.

## Operation
- Input conditioning: each pin passes through a 2-FF synchronizer, then a filter. The filter has a 4-bit counter per pin. The filtered output takes the synchronized value once that value has differed from the output for `FILT_LEN` consecutive cycles. The counter clears on any cycle where input equals output. Filtered reset values are 1.
- `fall` is a one-cycle pulse registered on a 1→0 transition of the filtered clock. Data is sampled from the filtered data in the same cycle.
- FSM states:
  - IDLE: on `fall` with data 0 (start bit), go to DATA, with `bit_cnt` at 0.
  - DATA: on each `fall`, shift the data in LSB first (right shift into bit 7). After the 8th bit, go to PARITY.
  - PARITY: on `fall`, capture the parity bit and go to STOP.
  - STOP: on `fall`, form the entry and go to IDLE.
  - IDLE with `fall` and data 1: ignored.
- Entry = {stop_err = ~data, parity_err = (parity_bit != ~^byte), byte}.
- The entry is pushed in the same cycle as the STOP `fall`, unless one of these holds:
  - `DROP_BAD`=1 and either error bit is set: entry discarded.
  - FIFO is full and no pop occurs in that cycle: entry discarded and `overflow` set.
- Watchdog: the counter clears on every `fall` and whenever the FSM is in IDLE. In any other state, reaching `TIMEOUT_CYC-1` forces IDLE, clears `bit_cnt`, pulses `timeout_pulse` and pushes nothing.
- `en` low takes priority over all transitions: the FSM goes to IDLE and the watchdog and `bit_cnt` clear. Filters and synchronizers keep running.
- FIFO: show-ahead. The head is on `m_*` whenever `m_valid`=1. A pop happens when `m_valid && m_ready`. Push and pop may occur in the same cycle, including when the FIFO is full or empty. On empty, a pushed entry becomes visible the next cycle; there is no bypass. Pointers wrap modulo `FIFO_DEPTH`, and the level is tracked in a separate counter.

## Timing
- Reset values:
  - `m_valid`, `fifo_level`, `timeout_pulse`, `overflow` = 0.
  - `m_data`, `m_parity_err`, `m_stop_err` = 0.
  - FSM in IDLE; filtered pins = 1.
- Pin to `fall` latency: 2 (sync) + `FILT_LEN` (filter) + 1 (edge register) cycles.
- Latency from the `fall` that samples the stop bit to `m_valid`: 1 cycle.
- `m_data` and flags stay stable while `m_valid`=1 and `m_ready`=0.
- Reset asserted mid-frame: the partial frame is lost and the FIFO is emptied asynchronously.
- A new start bit may follow the stop bit immediately; there is no dead time.

## Structure
- Package `ps2_pkg`:
  - `ps2_state_e` enum (IDLE, DATA, PARITY, STOP).
  - `ps2_entry_t` packed struct {stop_err, parity_err, data[7:0]}.
  - `PS2_DATA_BITS`=8 constant.
- Sub-module `ps2_sync_filt`, instantiated twice: 2-FF synchronizer plus the `FILT_LEN` filter. The FIFO is inline.

## Test plan
- Frame 0x1C, parity 0, stop 1, `m_ready`=1 → one entry: `m_data`=0x1C, both error flags 0, `fifo_level` returns to 0.
- Frame 0xF0 with parity 0 (wrong) → `m_parity_err`=1. Repeat with `DROP_BAD`=1 → no entry, `m_valid` stays 0.
- 1-cycle and 3-cycle low glitches on PS2_CLK with `FILT_LEN`=4 → no `fall`, FSM stays IDLE. A 5-cycle low pulse → accepted as an edge.
- Start bit plus 5 data bits, then clock stops → `timeout_pulse` exactly `TIMEOUT_CYC` cycles after the last `fall`. Then frame 0x5A → received correctly.
- `FIFO_DEPTH`=4, `m_ready`=0, frames 0x01..0x05 → `fifo_level`=4 and `overflow`=1. Draining yields 0x01..0x04; `ovf_clr` clears `overflow`.
- `en` dropped after 4 data bits, then raised, then frame 0x29 → only 0x29 is delivered. Reset mid-frame → all outputs return to their reset values.
